rsz_deser_stage: RTL and testbench
==================================

# rsz_deser_stage

Downstream capture stage for the register-to-buffer-chain test path: DFF launch, buffer chain through a hierarchical child, output port. It samples the single-bit stream arriving at the chain's output port and deserializes it LSB-first into WIDTH-bit words. Completed words are held in a 2-entry output buffer with a valid/ready handshake. The path under resizer buffer removal therefore terminates in real sequential logic with observable, checkable state.

## Interface
- WIDTH, 8, data bits per word (2..32).
- clk  in  1  rising-edge clock, same domain as the launching DFF.
- rst_n  in  1  asynchronous, active-low reset.
- sin  in  1  serial data bit, driven by the buffer-chain output net.
- sin_vld  in  1  sin is sampled only on cycles where this is 1.
- flush  in  1  synchronous clear of bit counter and output buffer.
- word  out  WIDTH  head-of-buffer word; 0 when empty.
- word_vld  out  1  buffer non-empty.
- word_rdy  in  1  consumer accepts head when word_vld && word_rdy.
- word_err  out  1  parity error tag of head entry; 0 when empty or parity compiled out.
- overflow  out  1  sticky: a completed word was dropped.

## Operation
- State machine: DATA (collecting bits 0..WIDTH-1) and PAR (expecting parity bit, only with PARITY_EN). Reset and flush enter DATA with bit counter 0.
- DATA: each sampled bit is shifted in LSB-first; bit k lands in word[k]. When bit WIDTH-1 is sampled: without parity, push the word and stay in DATA, counter 0. With parity, go to PAR.
- PAR: sampled bit is the parity bit; push word with err = XOR(data bits, parity bit), so even parity over WIDTH+1 bits; return to DATA.
- Cycles with sin_vld=0 hold all state; there is no timeout.
- Output buffer: 2 entries, FIFO order, each entry = {word, err}.
- Push when full and no pop in the same cycle: new word dropped, buffer unchanged, overflow set to 1 until rst_n.
- Push and pop in the same cycle when full: both take effect; buffer remains 2 entries, new word at tail.
- Push and pop in the same cycle when 1 entry: count stays 1, new word becomes head.
- flush wins over push/pop in the same cycle: counter 0, buffer empty, partial word discarded. overflow is not cleared.
- Reset values: word=0, word_vld=0, word_err=0, overflow=0, counter=0, state DATA.
- rst_n assertion mid-word or with buffered entries discards everything immediately (asynchronous); outputs reach reset values without a clock.

## Timing
- sin/sin_vld sampled on rising clk edge.
- Latency: word_vld rises the cycle after the edge sampling the last bit (data bit WIDTH-1, or the parity bit).
- Sustained throughput: one bit per cycle; one word per WIDTH cycles (WIDTH+1 with parity).
- word, word_vld, word_err and overflow are registered; no combinational path from sin.
- word_rdy affects state only at the clock edge; no combinational path from word_rdy to outputs.
- Head changes on the edge where a pop occurs.

## Configuration
- RSZ_DESER_PARITY_EN defined: PAR state present; frame = WIDTH+1 bits; word_err reflects the stored parity check.
- Not defined: PAR state, parity logic and err storage are removed; frame = WIDTH bits; word_err tied 0.

## Test plan
- Reset, WIDTH=8, no parity, word_rdy=1: send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> word=0xA5 and word_vld=1 for exactly one cycle, starting the cycle after the 8th bit.
- word_rdy=0: send 0x11, 0x22, 0x33 -> buffer holds 0x11 then 0x22, overflow=1 after the third word; raising word_rdy -> pops 0x11, then 0x22, then word_vld=0.
- Buffer full with 0x11/0x22 and word_rdy=1 on the cycle 0x33 completes -> subsequent pops give 0x22 then 0x33, overflow stays 0.
- sin_vld toggled 1,0,1,0 during 0x5A; flush asserted after 4 bits of a second word -> 0x5A delivered; partial word discarded; the next 8 bits form a clean word.
- PARITY_EN: send 0xA5 with parity 0 -> word_err=0. Send 0xA5 with parity 1 -> word=0xA5, word_err=1.
- Assert rst_n=0 asynchronously with 2 words buffered and 3 bits shifted -> word_vld=0, word=0, overflow=0 before the next clk edge.

Source files
------------

// File: rtl/rsz_deser_stage.sv
// rsz_deser_stage
// Capture stage at the far end of the register -> buffer chain test path.
// Samples the serial stream from the chain output, deserializes it LSB-first
// into WIDTH-bit words and queues completed words in a 2-entry buffer that is
// drained through a valid/ready handshake.
//
// Optional feature macro: RSZ_DESER_PARITY_EN
//   defined   : each frame carries a trailing even-parity bit, and word_err
//               tags the head entry with the parity check result
//   undefined : frame is WIDTH bits, no parity storage, and word_err is held at 0
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   sin       in   serial data bit
//   sin_vld   in   qualifies sin for the current cycle
//   flush     in   synchronous clear of bit counter, partial word and buffer
//   word      out  head-of-buffer word (0 when empty)
//   word_vld  out  buffer non-empty
//   word_rdy  in   consumer accepts head when word_vld && word_rdy
//   word_err  out  parity error tag of the head entry
//   overflow  out  sticky: a completed word was dropped (cleared by rst_n only)
//
// state   | meaning
// --------+------------------------------------------------
// ST_DATA | collecting data bits 0..WIDTH-1
// ST_PAR  | waiting for the parity bit (parity builds only)

module rsz_deser_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             flush,
  output logic [WIDTH-1:0] word,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             word_err,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef RSZ_DESER_PARITY_EN
  // Parity needs the whole word held while the parity bit arrives.
  localparam int SW = WIDTH;
  localparam int EW = WIDTH + 1;
  typedef enum logic {ST_DATA = 1'b0, ST_PAR = 1'b1} state_t;
`else
  // Without parity the last data bit is pushed straight from sin, so the
  // shift register only has to remember the first WIDTH-1 bits.
  localparam int SW = WIDTH - 1;
  localparam int EW = WIDTH;
  typedef enum logic {ST_DATA = 1'b0} state_t;
`endif

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   bit_cnt;
  logic [SW-1:0]   shreg;
  logic [WIDTH-1:0] shifted;
  logic            push;
  logic [EW-1:0]   push_ent;
  logic            pop;
  logic [EW-1:0]   head_q;
  logic [EW-1:0]   tail_q;
  logic [1:0]      cnt_q;
  logic            ovf_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_DATA;
    else        state <= state_nx;
  end

  // FSM next state and push request
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    push_ent = '0;
    shifted  = {sin, shreg[SW-1 -: WIDTH-1]};
    if (flush) begin
      state_nx = ST_DATA;
    end else if (sin_vld) begin
      case (state)
        ST_DATA: begin
          if (bit_cnt == LAST) begin
`ifdef RSZ_DESER_PARITY_EN
            state_nx = ST_PAR;
`else
            push     = 1'b1;
            push_ent = shifted;
`endif
          end
        end
`ifdef RSZ_DESER_PARITY_EN
        ST_PAR: begin
          // Even parity over WIDTH+1 bits: a nonzero XOR flags an error.
          push     = 1'b1;
          push_ent = {(^shreg) ^ sin, shreg};
          state_nx = ST_DATA;
        end
`endif
        default: state_nx = ST_DATA;
      endcase
    end
  end

  // Bit counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (flush) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (sin_vld && (state == ST_DATA)) begin
      shreg   <= shifted[WIDTH-1 -: SW];
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
    end
  end

  assign pop = (cnt_q != 2'd0) && word_rdy;

  // Two-entry output buffer. The head register is cleared whenever the
  // buffer empties so that word/word_err read 0 without extra gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= push_ent;
          end else begin
            head_q <= tail_q;
            tail_q <= push_ent;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          tail_q <= '0;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= push_ent;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_q <= push_ent;
            cnt_q  <= 2'd2;
          end else begin
            ovf_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign word     = head_q[WIDTH-1:0];
  assign word_vld = (cnt_q != 2'd0);
  assign overflow = ovf_q;
`ifdef RSZ_DESER_PARITY_EN
  assign word_err = head_q[WIDTH];
`else
  assign word_err = 1'b0;
`endif

endmodule

// File: tb/tb_rsz_deser_stage.sv
module tb_rsz_deser_stage;

  localparam int WIDTH = 8;
`ifdef RSZ_DESER_PARITY_EN
  localparam int FR  = WIDTH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FR  = WIDTH;
  localparam bit PAR = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             sin;
  logic             sin_vld;
  logic             flush;
  logic [WIDTH-1:0] word;
  logic             word_vld;
  logic             word_rdy;
  logic             word_err;
  logic             overflow;

  rsz_deser_stage #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .sin_vld  (sin_vld),
    .flush    (flush),
    .word     (word),
    .word_vld (word_vld),
    .word_rdy (word_rdy),
    .word_err (word_err),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits collected per frame, buffer occupancy, sticky flag.
  // sb holds the expected {err, word} entries currently in the buffer.
  logic [WIDTH:0] sb[$];
  bit             bits[$];
  int             m_cnt;
  bit             m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    bits.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Effect of one rising edge given the inputs that were applied to it.
  task automatic model_edge(input bit s, input bit v, input bit f, input bit r);
    bit             do_pop;
    bit             do_push;
    bit             full;
    logic [WIDTH:0] ent;
    logic [WIDTH-1:0] w;
    bit             p;
    do_pop  = (m_cnt > 0) && r;
    full    = (m_cnt == 2);
    do_push = 1'b0;
    ent     = '0;
    if (f) begin
      bits.delete();
      sb.delete();
      m_cnt = 0;
      return;
    end
    if (v) begin
      bits.push_back(s);
      if (bits.size() == FR) begin
        w = '0;
        p = 1'b0;
        for (int k = 0; k < FR; k++) begin
          if (k < WIDTH) w[k] = bits[k];
          p ^= bits[k];
        end
        ent     = {PAR ? p : 1'b0, w};
        do_push = 1'b1;
        bits.delete();
      end
    end
    if (do_pop) m_cnt--;
    if (do_push) begin
      if (full && !do_pop) m_ovf = 1'b1;
      else begin
        m_cnt++;
        sb.push_back(ent);
      end
    end
  endtask

  // Monitor: mid-cycle, outputs reflect the last edge and inputs are the ones
  // the next edge will use, so a visible handshake is the pop about to happen.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("word_vld", {31'b0, word_vld}, {31'b0, (sb.size() != 0)});
      check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      if (word_vld !== 1'b1) begin
        check("empty_word", {{(32-WIDTH){1'b0}}, word}, 32'd0);
        check("empty_err", {31'b0, word_err}, 32'd0);
      end else if (word_rdy === 1'b1 && sb.size() > 0) begin
        logic [WIDTH:0] e;
        e = sb.pop_front();
        check("pop_word", {{(32-WIDTH){1'b0}}, word}, {{(32-WIDTH){1'b0}}, e[WIDTH-1:0]});
        check("pop_err", {31'b0, word_err}, {31'b0, e[WIDTH]});
      end
    end
  end

  task automatic cycle(input bit s, input bit v, input bit f, input bit r);
    sin      = s;
    sin_vld  = v;
    flush    = f;
    word_rdy = r;
    @(posedge clk);
    model_edge(s, v, f, r);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit par, input bit r, input bit gap);
    logic [WIDTH:0] f;
    f = {par, w};
    for (int k = 0; k < FR; k++) begin
      cycle(f[k], 1'b1, 1'b0, r);
      if (gap) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, r);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    sin      = 1'b0;
    sin_vld  = 1'b0;
    flush    = 1'b0;
    word_rdy = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    do_reset();
    check("rst_word_vld", {31'b0, word_vld}, 32'd0);
    check("rst_word", {{(32-WIDTH){1'b0}}, word}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_word_err", {31'b0, word_err}, 32'd0);

    // 0xA5 with consumer always ready
    send_word(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // three words against a stalled consumer: third is dropped
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("ovf_set", {31'b0, overflow}, 32'd1);
    idle(4, 1'b1);

    // full buffer, pop coincides with the third push
    do_reset();
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    begin
      logic [WIDTH:0] f;
      f = {1'b0, 8'h33};
      for (int k = 0; k < FR; k++) cycle(f[k], 1'b1, 1'b0, (k == FR - 1));
    end
    idle(4, 1'b1);
    check("ovf_clear", {31'b0, overflow}, 32'd0);

    // gapped sin_vld, then a flushed partial word, then a clean word
    send_word(8'h5A, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

`ifdef RSZ_DESER_PARITY_EN
    send_word(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    send_word(8'h07, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
`endif

    // asynchronous reset with two entries buffered, overflow set, 3 bits shifted
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    sin_vld = 1'b0;
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("arst_word_vld", {31'b0, word_vld}, 32'd0);
    check("arst_word", {{(32-WIDTH){1'b0}}, word}, 32'd0);
    check("arst_overflow", {31'b0, overflow}, 32'd0);
    check("arst_word_err", {31'b0, word_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'hC3, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 1) == 1));
    end

    // drain with a bounded budget
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("drain_vld", {31'b0, word_vld}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
